// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream valid/ready channel used to fill the program memory.
//   data  - stream byte (master -> slave)
//   valid - data is valid (master -> slave)
//   ready - slave accepts a byte; a transfer is valid & ready at a rising clk edge
interface prog_loader_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    modport master (output data, valid, input ready);
    modport slave (input data, valid, output ready);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: run-time writable 16x8 program memory for the TD4 core, filled over a
// byte stream and released to the CPU only after a trailing checksum byte matches.
//   clk      - system clock, rising edge
//   rst_n    - asynchronous active-low reset; clears state, counters and memory
//   load_req - one-cycle pulse that starts or restarts a load
//   s        - byte stream (slave side): data, valid in; ready out
//   addr     - CPU fetch address
//   command  - mem[addr], combinational
//   cpu_run  - a checksum-verified program is loaded
//   load_err - the last load failed its checksum
module prog_loader (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_req,
    prog_loader_if.slave       s,
    input  logic [3:0]         addr,
    output logic [7:0]         command,
    output logic               cpu_run,
    output logic               load_err
);
    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RUN, ERROR} state_t;
    state_t     state, state_nxt;
    logic [3:0] wcnt;
    logic [7:0] sum;
    logic [7:0] mem [16];
    logic       xfer, wr;
    assign s.ready  = (state == LOAD) || (state == CHECK);
    assign cpu_run  = state == RUN;
    assign load_err = state == ERROR;
    assign command  = mem[addr];
    assign xfer     = s.valid && s.ready;
    // A restart request wins over a same-cycle byte, which is then dropped.
    assign wr       = xfer && (state == LOAD) && !load_req;
    always_comb begin
        state_nxt = state;
        if (load_req)
            state_nxt = LOAD;
        else
            case (state)
                LOAD:    if (xfer && wcnt == 4'hf) state_nxt = CHECK;
                CHECK:   if (xfer) state_nxt = (s.data == sum) ? RUN : ERROR;
                default: ;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            wcnt  <= '0;
            sum   <= '0;
            for (int i = 0; i < 16; i++)
                mem[i] <= '0;
        end else begin
            state <= state_nxt;
            if (load_req) begin
                wcnt <= '0;
                sum  <= '0;
            end else if (wr) begin
                mem[wcnt] <= s.data;
                sum       <= sum + s.data;
                wcnt      <= wcnt + 4'd1;
            end
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader.
module tb_prog_loader;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       load_req = 0;
    logic [3:0] addr = 0;
    logic [7:0] command;
    logic       cpu_run, load_err;
    int         n_chk = 0;
    int         n_pass = 0;
    prog_loader_if sif ();
    prog_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_req (load_req),
        .s        (sif.slave),
        .addr     (addr),
        .command  (command),
        .cpu_run  (cpu_run),
        .load_err (load_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic pulse_req();
        load_req = 1;
        tick();
        load_req = 0;
    endtask
    task automatic send(input logic [7:0] b);
        sif.data  = b;
        sif.valid = 1;
        tick();
        sif.valid = 0;
    endtask
    task automatic outs(input string tag, input logic r, input logic run, input logic err);
        check({tag, "_ready"}, {7'd0, sif.ready}, {7'd0, r});
        check({tag, "_run"},   {7'd0, cpu_run},   {7'd0, run});
        check({tag, "_err"},   {7'd0, load_err},  {7'd0, err});
    endtask
    task automatic sweep(input string tag, input logic [7:0] base, input logic [7:0] step);
        for (int i = 0; i < 16; i++) begin
            addr = 4'(i);
            @(negedge clk);
            check($sformatf("%s_mem%0d", tag, i), command, 8'(base + step * 8'(i)));
        end
    endtask
    // Sends sixteen bytes base+step*i, with optional idle gaps carrying junk data.
    task automatic send_pattern(input logic [7:0] base, input logic [7:0] step, input bit gaps);
        for (int i = 0; i < 16; i++) begin
            if (gaps)
                repeat ($urandom_range(0, 2)) begin
                    sif.data = 8'($urandom);
                    tick();
                end
            send(8'(base + step * 8'(i)));
        end
    endtask
    function automatic logic [7:0] csum(input logic [7:0] base, input logic [7:0] step);
        logic [7:0] t = 0;
        for (int i = 0; i < 16; i++) t = t + 8'(base + step * 8'(i));
        return t;
    endfunction
    initial begin
        sif.data  = 0;
        sif.valid = 0;
        repeat (3) tick();
        outs("rst", 0, 0, 0);
        rst_n = 1;
        tick();
        sweep("rst", 8'h00, 8'h00);
        send(8'h99);
        outs("idle_byte", 0, 0, 0);
        addr = 0;
        #1 check("idle_byte_mem0", command, 8'h00);
        pulse_req();
        outs("req", 1, 0, 0);
        send_pattern(8'h00, 8'h01, 0);
        outs("check_state", 1, 0, 0);
        send(8'h78);
        outs("good", 0, 1, 0);
        addr = 5;
        #1 check("good_addr5", command, 8'h05);
        send(8'h55);
        outs("run_byte", 0, 1, 0);
        addr = 0;
        #1 check("run_byte_mem0", command, 8'h00);
        pulse_req();
        send_pattern(8'hff, 8'h00, 0);
        send(8'hf0);
        outs("wrap", 0, 1, 0);
        pulse_req();
        send_pattern(8'hff, 8'h00, 0);
        send(8'hef);
        outs("bad", 0, 0, 1);
        sweep("bad", 8'hff, 8'h00);
        pulse_req();
        outs("reload_req", 1, 0, 0);
        send_pattern(8'h01, 8'h03, 1);
        send(csum(8'h01, 8'h03));
        outs("gaps", 0, 1, 0);
        sweep("gaps", 8'h01, 8'h03);
        pulse_req();
        for (int i = 0; i < 7; i++) send(8'(8'h20 + i));
        load_req = 1;
        send(8'haa);
        load_req = 0;
        outs("restart", 1, 0, 0);
        addr = 7;
        #1 check("restart_mem7", command, 8'h16);
        addr = 6;
        #1 check("restart_mem6", command, 8'h26);
        send_pattern(8'h40, 8'h01, 0);
        outs("restart_16", 1, 0, 0);
        send(8'h78);
        outs("restart_run", 0, 1, 0);
        sweep("restart", 8'h40, 8'h01);
        pulse_req();
        for (int i = 0; i < 9; i++) send(8'(8'h60 + i));
        #2 rst_n = 0;
        #1 outs("midrst", 0, 0, 0);
        sweep("midrst", 8'h00, 8'h00);
        rst_n = 1;
        tick();
        outs("post_rst", 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Writable program memory for the TD4 core. It replaces the fixed instruction ROM with a 16×8 store filled at run time over a byte-stream valid/ready interface. A trailing checksum byte is verified before the CPU is released. The CPU-side fetch port keeps the ROM's behaviour: a 4-bit address in, an 8-bit command out, combinational, zero latency.

## Interface
- No parameters. Depth is fixed at 16 words; width is fixed at 8 bits.
- CLK  in  1  system clock, rising edge
- RST_N  in  1  asynchronous, active-low reset
- LOAD_REQ  in  1  one-cycle pulse; starts or restarts a program load
- IN_DATA  in  8  stream byte
- IN_VALID  in  1  IN_DATA valid
- IN_READY  out  1  loader accepts a byte; a transfer occurs when IN_VALID & IN_READY are high at a rising CLK edge
- ADDR  in  4  CPU fetch address
- COMMAND  out  8  mem[ADDR], combinational
- CPU_RUN  out  1  a valid program is loaded; the CPU may execute
- LOAD_ERR  out  1  the last load failed its checksum

## Operation
- States: IDLE, LOAD, CHECK, RUN, ERROR. IN_READY, CPU_RUN and LOAD_ERR are decoded from the state register (Moore outputs).
- Internal registers: 4-bit write counter WCNT and 8-bit running sum SUM.
- IDLE
  - IN_READY=0, CPU_RUN=0, LOAD_ERR=0.
  - LOAD_REQ → LOAD.
- Entry to LOAD from any state clears WCNT and SUM.
- LOAD
  - IN_READY=1.
  - Each transfer: mem[WCNT]<=IN_DATA; SUM<=SUM+IN_DATA (mod 256); WCNT<=WCNT+1.
  - The transfer at WCNT=15 → CHECK. WCNT wraps to 0.
- CHECK
  - IN_READY=1.
  - The next transfer is the checksum byte and is not written to memory.
  - IN_DATA==SUM → RUN; otherwise → ERROR.
- RUN
  - CPU_RUN=1, IN_READY=0.
  - LOAD_REQ → LOAD.
- ERROR
  - LOAD_ERR=1, CPU_RUN=0, IN_READY=0.
  - LOAD_REQ → LOAD.
- LOAD_REQ in LOAD or CHECK restarts the load: WCNT=0, SUM=0, state LOAD.
  - LOAD_REQ has priority over a same-cycle transfer. That byte is discarded: no memory write, no SUM update, no compare.
- IN_VALID while IN_READY=0 is ignored; no state change.
- Memory contents:
  - Bytes written before a restart or a failed check remain in memory; unwritten locations keep their previous contents.
  - COMMAND always reflects current memory, in every state. Gating the CPU is done by CPU_RUN only.
- Reset (RST_N low, asynchronous, at any time including mid-load):
  - State IDLE, IN_READY=0, CPU_RUN=0, LOAD_ERR=0.
  - WCNT=0, SUM=0.
  - All 16 memory words are 0x00, so COMMAND=0x00.

## Timing
- LOAD_REQ sampled high at edge k → IN_READY=1 and CPU_RUN=0 from just after edge k.
- A data transfer at edge k → the new byte is visible on COMMAND (when ADDR matches) just after edge k.
- A checksum transfer at edge k → CPU_RUN or LOAD_ERR is high just after edge k.
- Minimum load time is 17 cycles from the first IN_READY to CPU_RUN (16 data bytes + 1 checksum), with IN_VALID held high.
- Throughput is one byte per cycle; no bubbles are inserted by the loader.
- COMMAND has zero latency from ADDR; there is no clock dependency on the read path.

## Test plan
- Reset: assert RST_N low mid-cycle → all outputs drop to 0 immediately. Sweep ADDR 0..15 → COMMAND=0x00 everywhere.
- Good load: LOAD_REQ, then bytes 0x00..0x0F back-to-back, then checksum 0x78.
  - CPU_RUN=1 after the 17th transfer; LOAD_ERR=0.
  - ADDR=5 → COMMAND=0x05.
- Checksum wrap: sixteen 0xFF bytes, then checksum 0xF0 → CPU_RUN=1.
- Bad checksum: sixteen 0xFF bytes, then 0xEF → LOAD_ERR=1, CPU_RUN=0.
  - Follow with a good reload → LOAD_ERR clears on the LOAD_REQ edge and CPU_RUN=1 at the end.
- Backpressure/gaps: IN_VALID toggled randomly, and bytes presented in IDLE/RUN → only handshaken bytes are written, and in order.
- Restart and mid-load reset:
  - After 7 bytes, LOAD_REQ coincident with IN_VALID carrying 0xAA → 0xAA is not written, WCNT=0, and 17 further transfers are needed to reach RUN.
  - Separately, RST_N low after 9 bytes → IDLE and memory all 0x00.
